// File: rtl/axi_read_arb.sv
// axi_read_arb: round-robin N-to-1 read command arbiter; the returned stream is
// routed only to the granted client until that command's final beat.
module axi_read_arb #(
    parameter int AXI_ADDR_BITWIDTH = 29,
    parameter int AXI_DATA_BITWIDTH = 128,
    parameter int ARB_NUM = 3
) (
    input  logic                                   sys_clk,
    input  logic                                   sys_rst_n,
    input  logic [ARB_NUM-1:0]                     read_cmd_start,
    output logic [ARB_NUM-1:0]                     read_cmd_done,
    input  logic [ARB_NUM*AXI_ADDR_BITWIDTH-1:0]   read_cmd_addr,
    input  logic [ARB_NUM*AXI_ADDR_BITWIDTH-1:0]   read_cmd_len,
    output logic [ARB_NUM-1:0]                     read_axis_valid,
    input  logic [ARB_NUM-1:0]                     read_axis_ready,
    output logic [ARB_NUM*AXI_DATA_BITWIDTH-1:0]   read_axis_data,
    output logic [ARB_NUM-1:0]                     read_axis_last,
    output logic                                   arb_read_cmd_start,
    input  logic                                   arb_read_cmd_done,
    output logic [AXI_ADDR_BITWIDTH-1:0]           arb_read_cmd_addr,
    output logic [AXI_ADDR_BITWIDTH-1:0]           arb_read_cmd_len,
    input  logic                                   arb_read_axis_valid,
    output logic                                   arb_read_axis_ready,
    input  logic [AXI_DATA_BITWIDTH-1:0]           arb_read_axis_data,
    input  logic                                   arb_read_axis_last
);
    localparam int AW = AXI_ADDR_BITWIDTH;
    localparam int DW = AXI_DATA_BITWIDTH;
    localparam int IW = $clog2(ARB_NUM);
    localparam logic [IW-1:0] LAST_IDX = IW'(ARB_NUM - 1);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] rr_ptr, rr_nx, grant, grant_nx, win, cand, win_inc, grant_inc;
    logic          found, last_seen, last_nx, start_nx, active, beat_last;
    logic [ARB_NUM-1:0] done_nx;
    logic [AW-1:0] addr_nx, len_nx, win_addr, win_len;

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        win = '0;
        cand = '0;
        for (int i = 0; i < ARB_NUM; i++) begin
            cand = IW'((int'(rr_ptr) + i) % ARB_NUM);
            if (!found && read_cmd_start[cand]) begin
                found = 1'b1;
                win = cand;
            end
        end
    end

    assign win_addr  = read_cmd_addr[int'(win)*AW +: AW];
    assign win_len   = read_cmd_len[int'(win)*AW +: AW];
    assign win_inc   = (win == LAST_IDX) ? '0 : win + IW'(1);
    assign grant_inc = (grant == LAST_IDX) ? '0 : grant + IW'(1);
    assign active    = state != IDLE;
    assign beat_last = arb_read_axis_valid & arb_read_axis_ready & arb_read_axis_last;

    always_comb begin
        read_axis_valid = '0;
        read_axis_last = '0;
        read_axis_data = '0;
        arb_read_axis_ready = active & read_axis_ready[grant];
        for (int i = 0; i < ARB_NUM; i++) begin
            if (active && grant == IW'(i)) begin
                read_axis_valid[i] = arb_read_axis_valid;
                read_axis_last[i] = arb_read_axis_last;
                read_axis_data[i*DW +: DW] = arb_read_axis_data;
            end
        end
    end

    // A pending done pulse blocks the search so a client that has not yet
    // dropped its request is not granted twice for one command.
    always_comb begin
        state_nx = state;
        rr_nx = rr_ptr;
        grant_nx = grant;
        last_nx = last_seen;
        done_nx = '0;
        start_nx = arb_read_cmd_start;
        addr_nx = arb_read_cmd_addr;
        len_nx = arb_read_cmd_len;
        case (state)
            IDLE: begin
                if (found && read_cmd_done == '0) begin
                    done_nx[win] = 1'b1;
                    grant_nx = win;
                    addr_nx = win_addr;
                    len_nx = win_len;
                    start_nx = win_len != '0;
                    state_nx = (win_len != '0) ? CMD : IDLE;
                    rr_nx = (win_len != '0) ? rr_ptr : win_inc;
                end
            end
            CMD: begin
                last_nx = last_seen | beat_last;
                if (arb_read_cmd_done) begin
                    start_nx = 1'b0;
                    state_nx = last_nx ? IDLE : DATA;
                    rr_nx = last_nx ? grant_inc : rr_ptr;
                    last_nx = 1'b0;
                end
            end
            DATA: begin
                if (beat_last) begin
                    state_nx = IDLE;
                    rr_nx = grant_inc;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
            rr_ptr <= '0;
            grant <= '0;
            last_seen <= 1'b0;
            read_cmd_done <= '0;
            arb_read_cmd_start <= 1'b0;
            arb_read_cmd_addr <= '0;
            arb_read_cmd_len <= '0;
        end else begin
            state <= state_nx;
            rr_ptr <= rr_nx;
            grant <= grant_nx;
            last_seen <= last_nx;
            read_cmd_done <= done_nx;
            arb_read_cmd_start <= start_nx;
            arb_read_cmd_addr <= addr_nx;
            arb_read_cmd_len <= len_nx;
        end
    end
endmodule

// File: tb/tb_axi_read_arb.sv
// tb_axi_read_arb: directed stimulus against a transaction-level arbiter model,
// checked every cycle, plus literal expectations on grant order and beat counts.
module tb_axi_read_arb;
    localparam int AW = 29;
    localparam int DW = 128;
    localparam int N = 3;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    logic [N-1:0] read_cmd_start, read_cmd_done, read_axis_valid, read_axis_ready, read_axis_last;
    logic [N*AW-1:0] read_cmd_addr, read_cmd_len;
    logic [N*DW-1:0] read_axis_data;
    logic arb_read_cmd_start, arb_read_cmd_done, arb_read_axis_valid, arb_read_axis_ready, arb_read_axis_last;
    logic [AW-1:0] arb_read_cmd_addr, arb_read_cmd_len;
    logic [DW-1:0] arb_read_axis_data;

    int compared = 0;
    int failed = 0;
    int dcount[N] = '{default: 0};
    int lane_beats[N] = '{default: 0};
    int lane_last[N] = '{default: 0};
    int startcnt = 0;
    int gq[$];
    logic [DW-1:0] l0q[$];
    logic [N-1:0] hold = '0;
    logic [3:0] pat = 4'b1001;

    // model: owner of the outstanding transaction (-1 none), whether the master
    // still owes the command accept and the final beat
    int m_owner, m_ptr;
    bit m_cmd, m_data;
    logic [N-1:0] m_done;
    logic [AW-1:0] m_addr, m_len;

    always #5 sys_clk = ~sys_clk;

    axi_read_arb #(.AXI_ADDR_BITWIDTH(AW), .AXI_DATA_BITWIDTH(DW), .ARB_NUM(N)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .read_cmd_start(read_cmd_start), .read_cmd_done(read_cmd_done),
        .read_cmd_addr(read_cmd_addr), .read_cmd_len(read_cmd_len),
        .read_axis_valid(read_axis_valid), .read_axis_ready(read_axis_ready),
        .read_axis_data(read_axis_data), .read_axis_last(read_axis_last),
        .arb_read_cmd_start(arb_read_cmd_start), .arb_read_cmd_done(arb_read_cmd_done),
        .arb_read_cmd_addr(arb_read_cmd_addr), .arb_read_cmd_len(arb_read_cmd_len),
        .arb_read_axis_valid(arb_read_axis_valid), .arb_read_axis_ready(arb_read_axis_ready),
        .arb_read_axis_data(arb_read_axis_data), .arb_read_axis_last(arb_read_axis_last)
    );

    task automatic chk(input string n, input logic [511:0] a, input logic [511:0] e);
        compared++;
        if (a !== e) begin
            failed++;
            $display("FAIL %s at %0t: got %0h, want %0h", n, $time, a, e);
        end
    endtask

    task automatic m_reset();
        m_owner = -1;
        m_ptr = 0;
        m_cmd = 0;
        m_data = 0;
        m_done = '0;
        m_addr = '0;
        m_len = '0;
    endtask

    task automatic m_step();
        logic [N-1:0] prev;
        int w;
        prev = m_done;
        m_done = '0;
        w = -1;
        if (m_owner >= 0) begin
            if (arb_read_axis_valid && read_axis_ready[m_owner] && arb_read_axis_last) m_data = 0;
            if (m_cmd && arb_read_cmd_done) m_cmd = 0;
            if (!m_cmd && !m_data) begin
                m_ptr = (m_owner + 1) % N;
                m_owner = -1;
            end
        end else if (prev == '0) begin
            for (int k = 0; k < N; k++)
                if (w < 0 && read_cmd_start[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            if (w >= 0) begin
                m_done[w] = 1'b1;
                m_addr = read_cmd_addr[w*AW +: AW];
                m_len = read_cmd_len[w*AW +: AW];
                if (m_len == '0) m_ptr = (w + 1) % N;
                else begin
                    m_owner = w;
                    m_cmd = 1;
                    m_data = 1;
                end
            end
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge sys_clk or negedge sys_rst_n);
            if (!sys_rst_n) m_reset();
            else m_step();
        end
    end

    initial begin
        logic [N-1:0] ev, el;
        logic [N*DW-1:0] ed;
        logic er;
        forever begin
            @(negedge sys_clk);
            #1;
            ev = '0; el = '0; ed = '0; er = 1'b0;
            if (m_owner >= 0) begin
                ev[m_owner] = arb_read_axis_valid;
                el[m_owner] = arb_read_axis_last;
                ed[m_owner*DW +: DW] = arb_read_axis_data;
                er = read_axis_ready[m_owner];
            end
            chk("cmd_done", read_cmd_done, m_done);
            chk("arb_start", arb_read_cmd_start, m_owner >= 0 && m_cmd);
            chk("arb_addr", arb_read_cmd_addr, m_addr);
            chk("arb_len", arb_read_cmd_len, m_len);
            chk("arb_ready", arb_read_axis_ready, er);
            chk("lane_valid", read_axis_valid, ev);
            chk("lane_last", read_axis_last, el);
            chk("lane_data", read_axis_data, ed);
            for (int i = 0; i < N; i++) begin
                if (read_cmd_done[i]) begin
                    dcount[i]++;
                    gq.push_back(i);
                end
                if (read_axis_valid[i] && read_axis_ready[i]) begin
                    lane_beats[i]++;
                    if (read_axis_last[i]) lane_last[i]++;
                    if (i == 0) l0q.push_back(read_axis_data[DW-1:0]);
                end
            end
            if (arb_read_cmd_start) startcnt++;
        end
    end

    task automatic cyc();
        @(negedge sys_clk);
        for (int i = 0; i < N; i++)
            if (read_cmd_done[i] && !hold[i]) read_cmd_start[i] = 1'b0;
    endtask

    task automatic req(input int c, input logic [AW-1:0] a, input logic [AW-1:0] l);
        read_cmd_addr[c*AW +: AW] = a;
        read_cmd_len[c*AW +: AW] = l;
        read_cmd_start[c] = 1'b1;
    endtask

    task automatic wait_start();
        int k = 0;
        while (!arb_read_cmd_start && k < 20) begin
            cyc();
            k++;
        end
        compared++;
        if (k >= 20) begin
            failed++;
            $display("FAIL start_wait: arb_read_cmd_start low for %0d cycles, want 1", k);
        end
    endtask

    task automatic accept();
        cyc();
        arb_read_cmd_done = 1'b1;
        cyc();
        arb_read_cmd_done = 1'b0;
    endtask

    task automatic beats(input int nb, input bit bp, input int base);
        int b = 0;
        int g = 0;
        bit x;
        while (b < nb && g < 40) begin
            if (bp) read_axis_ready[0] = (g < 4) ? pat[g] : 1'b1;
            arb_read_axis_valid = 1'b1;
            arb_read_axis_data = DW'(base + b);
            arb_read_axis_last = (b == nb - 1);
            #1 x = arb_read_axis_ready;
            cyc();
            if (x) b++;
            g++;
        end
        arb_read_axis_valid = 1'b0;
        arb_read_axis_last = 1'b0;
        read_axis_ready[0] = 1'b1;
        compared++;
        if (b < nb) begin
            failed++;
            $display("FAIL beat_wait: delivered %0d beats, want %0d", b, nb);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int d, s, g0, q0, b1;
        read_cmd_start = '0;
        read_cmd_addr = '0;
        read_cmd_len = '0;
        read_axis_ready = '1;
        arb_read_cmd_done = 1'b0;
        arb_read_axis_valid = 1'b0;
        arb_read_axis_last = 1'b0;
        arb_read_axis_data = '0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        cyc();

        // single client
        d = dcount[1];
        req(1, 'h100, 64);
        wait_start();
        chk("t1_addr", arb_read_cmd_addr, 'h100);
        chk("t1_len", arb_read_cmd_len, 64);
        accept();
        beats(4, 0, 'h1000);
        repeat (2) cyc();
        chk("t1_done_pulses", dcount[1] - d, 1);
        chk("t1_lane1_beats", lane_beats[1], 4);
        chk("t1_lane1_last", lane_last[1], 1);
        chk("t1_other_lanes", lane_beats[0] + lane_beats[2], 0);

        // zero length: ack without a master command, pointer wraps to 0
        d = dcount[2];
        s = startcnt;
        req(2, 'h200, 0);
        repeat (4) cyc();
        chk("t3_done2", dcount[2] - d, 1);
        chk("t3_no_start", startcnt - s, 0);

        // round robin, client 0 re-requests immediately
        g0 = gq.size();
        hold[0] = 1'b1;
        req(0, 'h1000, 32);
        req(1, 'h2000, 32);
        req(2, 'h3000, 32);
        for (int t = 0; t < 4; t++) begin
            if (t == 3) hold[0] = 1'b0;
            wait_start();
            accept();
            beats(2, 0, 'h2000 + 16 * t);
        end
        repeat (3) cyc();
        chk("t2_grants", gq.size() - g0, 4);
        chk("t2_order0", gq[g0], 0);
        chk("t2_order1", gq[g0+1], 1);
        chk("t2_order2", gq[g0+2], 2);
        chk("t2_order3", gq[g0+3], 0);

        // early data: final beat before the master accepts the command
        b1 = lane_beats[2];
        req(2, 'h300, 16);
        wait_start();
        arb_read_axis_valid = 1'b1;
        arb_read_axis_last = 1'b1;
        arb_read_axis_data = DW'('h3333);
        cyc();
        arb_read_axis_valid = 1'b0;
        arb_read_axis_last = 1'b0;
        arb_read_cmd_done = 1'b1;
        cyc();
        arb_read_cmd_done = 1'b0;
        arb_read_axis_valid = 1'b1;
        #1;
        chk("t4_lane2_beat", lane_beats[2] - b1, 1);
        chk("t4_idle_ready", arb_read_axis_ready, 0);
        chk("t4_idle_valid", read_axis_valid, 0);
        cyc();
        arb_read_axis_valid = 1'b0;
        cyc();

        // backpressure on client 0
        q0 = l0q.size();
        b1 = lane_beats[1] + lane_beats[2];
        req(0, 'h400, 48);
        wait_start();
        accept();
        beats(3, 1, 'h400);
        cyc();
        chk("t5_beats", l0q.size() - q0, 3);
        chk("t5_beat0", l0q[q0], 'h400);
        chk("t5_beat1", l0q[q0+1], 'h401);
        chk("t5_beat2", l0q[q0+2], 'h402);
        chk("t5_other_lanes", lane_beats[1] + lane_beats[2] - b1, 0);

        // reset after beat 2 of 4
        b1 = lane_beats[1];
        req(1, 'h500, 64);
        wait_start();
        accept();
        for (int b = 0; b < 2; b++) begin
            arb_read_axis_valid = 1'b1;
            arb_read_axis_data = DW'('h500 + b);
            cyc();
        end
        arb_read_axis_data = DW'('h502);
        sys_rst_n = 1'b0;
        read_cmd_start = '0;
        #1;
        chk("t6_beats_before", lane_beats[1] - b1, 2);
        chk("t6_rst_ready", arb_read_axis_ready, 0);
        chk("t6_rst_valid", read_axis_valid, 0);
        chk("t6_rst_data", read_axis_data, 0);
        chk("t6_rst_start", arb_read_cmd_start, 0);
        chk("t6_rst_addr", arb_read_cmd_addr, 0);
        cyc();
        arb_read_axis_valid = 1'b0;
        cyc();
        sys_rst_n = 1'b1;
        cyc();
        g0 = gq.size();
        req(2, 'h600, 16);
        req(0, 'h700, 16);
        for (int t = 0; t < 2; t++) begin
            wait_start();
            accept();
            beats(1, 0, 'h600 + 16 * t);
        end
        repeat (3) cyc();
        chk("t6_grants", gq.size() - g0, 2);
        chk("t6_first", gq[g0], 0);
        chk("t6_second", gq[g0+1], 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
